// File: rtl/bbox_sample_scan_pkg.sv
// Shared definitions for the bounding-box raster-scan stage: Q10.6 format
// constants, default sample pitch, packed-triangle layout and FSM states.
package bbox_sample_scan_pkg;

  // Signed Q10.6 fixed point: 16 bits total, 6 fractional bits.
  localparam int Q_W    = 16;
  localparam int Q_FRAC = 6;

  // One whole pixel in Q10.6 LSBs.
  localparam int STEP_DEFAULT = 1 << Q_FRAC;

  // Packed triangle {v0x,v0y,v1x,v1y,v2x,v2y}, v0x in the MSBs.
  localparam int TRI_W   = 6 * Q_W;
  localparam int V0X_LSB = 5 * Q_W;
  localparam int V0Y_LSB = 4 * Q_W;
  localparam int V1X_LSB = 3 * Q_W;
  localparam int V1Y_LSB = 2 * Q_W;
  localparam int V2X_LSB = 1 * Q_W;
  localparam int V2Y_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Whole-pixel value expressed in Q10.6, computed at full int width so that
  // screen limits beyond the Q10.6 range do not wrap.
  function automatic int pix_to_q(input int pix);
    return pix * (1 << Q_FRAC);
  endfunction

endpackage

// File: rtl/bbox_sample_scan_clip.sv
// bbox_clip: combinational clamp of a Q10.6 bounding box to the visible
// screen [0, (SCREEN_W-1)] x [0, (SCREEN_H-1)] pixels. Only instantiated when
// BBOX_SCREEN_CLIP_EN is defined. A box lying fully off-screen comes out with
// min > max, which the scanner treats as empty.
module bbox_clip
  import bbox_sample_scan_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic [Q_W-1:0] xmin,
  input  logic [Q_W-1:0] xmax,
  input  logic [Q_W-1:0] ymin,
  input  logic [Q_W-1:0] ymax,
  output logic [Q_W-1:0] xmin_clip,
  output logic [Q_W-1:0] xmax_clip,
  output logic [Q_W-1:0] ymin_clip,
  output logic [Q_W-1:0] ymax_clip
);

  // Right/bottom limits may exceed the Q10.6 range (640 px does); comparing
  // in int keeps that case a harmless no-op instead of a wrapped clamp.
  localparam int X_LIM = pix_to_q(SCREEN_W - 1);
  localparam int Y_LIM = pix_to_q(SCREEN_H - 1);

  logic signed [Q_W-1:0] sxmin, sxmax, symin, symax;

  assign sxmin = xmin;
  assign sxmax = xmax;
  assign symin = ymin;
  assign symax = ymax;

  // Clamp each bound independently; max bounds are truncated only when the
  // limit is below them, so the limit is guaranteed to fit in Q10.6.
  always_comb begin
    xmin_clip = xmin;
    xmax_clip = xmax;
    ymin_clip = ymin;
    ymax_clip = ymax;
    if (sxmin < 0) xmin_clip = '0;
    if (symin < 0) ymin_clip = '0;
    if (int'(sxmax) > X_LIM) xmax_clip = 16'(X_LIM);
    if (int'(symax) > Y_LIM) ymax_clip = 16'(Y_LIM);
  end

endmodule

// File: rtl/bbox_sample_scan.sv
// bbox_sample_scan: walks every integer sample point of a triangle's bounding
// box in row-major order, one sample per cycle, with valid/ready on both
// sides. Optional screen clipping is enabled by defining BBOX_SCREEN_CLIP_EN.
module bbox_sample_scan
  import bbox_sample_scan_pkg::*;
#(
  parameter int STEP     = STEP_DEFAULT,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TRI_W-1:0]  in_tri,
  input  logic [Q_W-1:0]    in_xmin,
  input  logic [Q_W-1:0]    in_xmax,
  input  logic [Q_W-1:0]    in_ymin,
  input  logic [Q_W-1:0]    in_ymax,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    out_x,
  output logic [Q_W-1:0]    out_y,
  output logic [TRI_W-1:0]  out_tri,
  output logic              out_last,
  output logic              tri_done
);

  localparam logic signed [Q_W:0] STEP_W = (Q_W+1)'(STEP);

  // Advance a coordinate by one pitch. The sum is formed one bit wider; it is
  // only ever taken when the coordinate is strictly below its bound, so the
  // low Q_W bits are always the correct next sample.
  function automatic logic signed [Q_W-1:0] step_up(input logic signed [Q_W-1:0] v);
    logic signed [Q_W:0] w;
    w = {v[Q_W-1], v} + STEP_W;
    return w[Q_W-1:0];
  endfunction

  state_t state, state_nx;

  logic signed [Q_W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic signed [Q_W-1:0] cur_x, cur_y;
  logic signed [Q_W-1:0] xmin_r, xmax_r, ymax_r;
  logic [TRI_W-1:0]      tri_r;
  logic                  done_r, done_nx;
  logic                  accept, fire, at_xmax, at_last, box_empty;

`ifdef BBOX_SCREEN_CLIP_EN
  logic [Q_W-1:0] clip_xmin, clip_xmax, clip_ymin, clip_ymax;

  bbox_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .xmin      (in_xmin),
    .xmax      (in_xmax),
    .ymin      (in_ymin),
    .ymax      (in_ymax),
    .xmin_clip (clip_xmin),
    .xmax_clip (clip_xmax),
    .ymin_clip (clip_ymin),
    .ymax_clip (clip_ymax)
  );

  assign box_xmin = clip_xmin;
  assign box_xmax = clip_xmax;
  assign box_ymin = clip_ymin;
  assign box_ymax = clip_ymax;
`else
  assign box_xmin = in_xmin;
  assign box_xmax = in_xmax;
  assign box_ymin = in_ymin;
  assign box_ymax = in_ymax;
`endif

  // Signed comparison: an inverted box on either axis holds no samples.
  assign box_empty = (box_xmin > box_xmax) || (box_ymin > box_ymax);

  // Equality against the bound (not greater-than after increment) keeps
  // scans that end near +32767 from wrapping.
  assign at_xmax = (cur_x == xmax_r);
  assign at_last = at_xmax && (cur_y == ymax_r);

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  assign out_x    = cur_x;
  assign out_y    = cur_y;
  assign out_tri  = tri_r;
  assign tri_done = done_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic, handshake outputs and the retire pulse request.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (box_empty) done_nx  = 1'b1;
          else           state_nx = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready && at_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Retire pulse lands the cycle after the final handshake or empty accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_r <= 1'b0;
    else        done_r <= done_nx;
  end

  // Descriptor capture and scan cursor: load on accept, step on each
  // non-final handshake, otherwise hold so outputs stay stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x  <= '0;
      cur_y  <= '0;
      xmin_r <= '0;
      xmax_r <= '0;
      ymax_r <= '0;
      tri_r  <= '0;
    end else if (accept) begin
      cur_x  <= box_xmin;
      cur_y  <= box_ymin;
      xmin_r <= box_xmin;
      xmax_r <= box_xmax;
      ymax_r <= box_ymax;
      tri_r  <= in_tri;
    end else if (fire && !at_last) begin
      if (at_xmax) begin
        cur_x <= xmin_r;
        cur_y <= step_up(cur_y);
      end else begin
        cur_x <= step_up(cur_x);
      end
    end
  end

endmodule

// File: tb/tb_bbox_sample_scan.sv
// Self-checking bench for bbox_sample_scan. Expected samples are generated
// from the box by an independent integer raster model (with screen clipping
// when BBOX_SCREEN_CLIP_EN is defined) and queued before each descriptor is
// sent; the output side pops and compares on every handshake.
module tb_bbox_sample_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_tri;
  logic [15:0] in_xmin, in_xmax, in_ymin, in_ymax;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x, out_y;
  logic [95:0] out_tri;
  logic        out_last;
  logic        tri_done;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [95:0] tri_v;
    logic        last;
  } samp_t;

  samp_t sb[$];
  int    tests = 0;
  int    fails = 0;

  bbox_sample_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tri    (in_tri),
    .in_xmin   (in_xmin),
    .in_xmax   (in_xmax),
    .in_ymin   (in_ymin),
    .in_ymax   (in_ymax),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_tri   (out_tri),
    .out_last  (out_last),
    .tri_done  (tri_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Queue the expected row-major sample sequence for one box.
  task automatic push_box(input logic [95:0] t, input int xmin, input int xmax,
                          input int ymin, input int ymax, output int n);
    int x0, x1, y0, y1;
    samp_t s;
    x0 = xmin; x1 = xmax; y0 = ymin; y1 = ymax;
`ifdef BBOX_SCREEN_CLIP_EN
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > 639 * 64) x1 = 639 * 64;
    if (y1 > 479 * 64) y1 = 479 * 64;
`endif
    n = 0;
    for (int y = y0; y <= y1; y += 64) begin
      for (int x = x0; x <= x1; x += 64) begin
        s.x     = 16'(x);
        s.y     = 16'(y);
        s.tri_v = t;
        s.last  = (x == x1) && (y == y1);
        sb.push_back(s);
        n++;
      end
    end
  endtask

  // Present one descriptor for exactly one cycle; scramble in_tri afterwards.
  task automatic send(input logic [95:0] t, input int xmin, input int xmax,
                      input int ymin, input int ymax);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_tri   = t;
    in_xmin  = 16'(xmin);
    in_xmax  = 16'(xmax);
    in_ymin  = 16'(ymin);
    in_ymax  = 16'(ymax);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_in_ready got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_tri   = {$urandom, $urandom, $urandom};
    in_xmin  = 16'($urandom);
    in_xmax  = 16'($urandom);
  endtask

  // Scoreboard consumer: pops one expected sample per handshake, checks
  // stall stability, then the retire cycle.
  task automatic consume(input bit rnd_stall, input int budget);
    int          cyc;
    bit          stalled, done;
    logic [15:0] hx, hy;
    logic [95:0] ht;
    samp_t       s;
    cyc = 0; stalled = 0; done = 0;
    hx = '0; hy = '0; ht = '0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        tests++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL first_sample_latency out_valid=%b required=1", out_valid);
        end
      end
      if (stalled) begin
        tests++;
        if (out_x !== hx || out_y !== hy || out_tri !== ht || out_valid !== 1'b1) begin
          fails++;
          $display("FAIL stall_hold x=%0d y=%0d v=%b required x=%0d y=%0d v=1",
                   $signed(out_x), $signed(out_y), out_valid, $signed(hx), $signed(hy));
        end
      end
      tests++;
      if (tri_done !== 1'b0) begin
        fails++;
        $display("FAIL tri_done_during_scan got=%b required=0", tri_done);
      end
      if (out_valid && out_ready) begin
        stalled = 0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_sample x=%0d y=%0d required none", $signed(out_x), $signed(out_y));
        end else begin
          s = sb.pop_front();
          if (out_x !== s.x || out_y !== s.y || out_tri !== s.tri_v || out_last !== s.last) begin
            fails++;
            $display("FAIL sample got x=%0d y=%0d last=%b tri=%h required x=%0d y=%0d last=%b tri=%h",
                     $signed(out_x), $signed(out_y), out_last, out_tri,
                     $signed(s.x), $signed(s.y), s.last, s.tri_v);
          end
          if (s.last) done = 1;
        end
      end else if (out_valid) begin
        stalled = 1;
        hx = out_x; hy = out_y; ht = out_tri;
      end else begin
        stalled = 0;
      end
      @(posedge clk); #1;
      if (rnd_stall) out_ready = ($urandom_range(0, 1) == 1);
    end
    out_ready = 1'b1;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL scan_timeout got %0d samples left, required 0 within %0d cycles", sb.size(), budget);
      sb.delete();
    end else begin
      @(negedge clk);
      if (tri_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL retire tri_done=%b out_valid=%b in_ready=%b required 1 0 1",
                 tri_done, out_valid, in_ready);
      end
      @(negedge clk);
      tests++;
      if (tri_done !== 1'b0) begin
        fails++;
        $display("FAIL tri_done_width got=%b required=0", tri_done);
      end
    end
  endtask

  // Empty-box path: no samples, single tri_done pulse, in_ready stays high.
  task automatic expect_empty();
    @(negedge clk);
    tests++;
    if (tri_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL empty_retire tri_done=%b out_valid=%b in_ready=%b required 1 0 1",
               tri_done, out_valid, in_ready);
    end
    @(negedge clk);
    tests++;
    if (tri_done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL empty_after tri_done=%b out_valid=%b required 0 0", tri_done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_tri = '0; in_xmin = '0; in_xmax = '0; in_ymin = '0; in_ymax = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || tri_done !== 1'b0 ||
        out_x !== 16'h0 || out_y !== 16'h0 || out_tri !== 96'h0) begin
      fails++;
      $display("FAIL reset_values in_ready=%b out_valid=%b out_last=%b tri_done=%b x=%h y=%h tri=%h required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_last, tri_done, out_x, out_y, out_tri);
    end
  endtask

  task automatic test_basic();
    logic [95:0] t;
    int n;
    t = 96'h0040_0000_00C0_0000_0080_0040;
    push_box(t, 64, 192, 0, 64, n);
    send(t, 64, 192, 0, 64);
    consume(1'b0, 20);
  endtask

  task automatic test_one_pixel();
    logic [95:0] t;
    int n;
    t = {$urandom, $urandom, $urandom};
    push_box(t, 320, 320, 320, 320, n);
    send(t, 320, 320, 320, 320);
    consume(1'b0, 5);
  endtask

  task automatic test_random_stall();
    logic [95:0] t;
    int n;
    t = {$urandom, $urandom, $urandom};
    push_box(t, -64, 64, 128, 256, n);
    send(t, -64, 64, 128, 256);
    out_ready = 1'b0;
    consume(1'b1, 300);
  endtask

  task automatic test_top_edge();
    logic [95:0] t;
    int n;
    t = {$urandom, $urandom, $urandom};
    push_box(t, 32640, 32704, 32640, 32704, n);
    send(t, 32640, 32704, 32640, 32704);
    consume(1'b0, 10);
  endtask

  task automatic test_empty();
    send(96'h1, 128, 64, 0, 0);
    expect_empty();
    send(96'h2, 0, 0, 64, -64);
    expect_empty();
  endtask

  task automatic test_negative_box();
    logic [95:0] t;
    int n;
    t = {$urandom, $urandom, $urandom};
    push_box(t, -128, 64, -64, 0, n);
    send(t, -128, 64, -64, 0);
    consume(1'b0, 20);
    t = {$urandom, $urandom, $urandom};
    push_box(t, -256, -64, 0, 0, n);
    send(t, -256, -64, 0, 0);
    if (n == 0) expect_empty();
    else        consume(1'b0, 20);
  endtask

  task automatic test_back_to_back();
    logic [95:0] t1, t2;
    int n;
    t1 = {$urandom, $urandom, $urandom};
    t2 = {$urandom, $urandom, $urandom};
    push_box(t1, 0, 128, 0, 0, n);
    send(t1, 0, 128, 0, 0);
    consume(1'b0, 10);
    push_box(t2, 192, 192, 64, 192, n);
    send(t2, 192, 192, 64, 192);
    consume(1'b0, 10);
  endtask

  task automatic test_reset_mid_scan();
    logic [95:0] t;
    int n;
    samp_t s;
    t = {$urandom, $urandom, $urandom};
    push_box(t, 0, 64, 0, 64, n);
    send(t, 0, 64, 0, 64);
    @(negedge clk);
    s = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || out_x !== s.x || out_y !== s.y) begin
      fails++;
      $display("FAIL rst_first_sample v=%b x=%0d y=%0d required 1 %0d %0d",
               out_valid, $signed(out_x), $signed(out_y), $signed(s.x), $signed(s.y));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_x !== 16'h0 || out_tri !== 96'h0) begin
      fails++;
      $display("FAIL rst_mid_scan out_valid=%b in_ready=%b x=%h tri=%h required 0 1 0 0",
               out_valid, in_ready, out_x, out_tri);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (tri_done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_retire tri_done=%b out_valid=%b required 0 0", tri_done, out_valid);
      end
    end
    t = {$urandom, $urandom, $urandom};
    push_box(t, 448, 512, 192, 256, n);
    send(t, 448, 512, 192, 256);
    consume(1'b0, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_pixel();
    test_random_stall();
    test_top_edge();
    test_empty();
    test_negative_box();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
